// File: rtl/slow_clock_period_meter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : slow_clock_period_meter_if                                    |
// | Purpose  : Slow-clock input, control and measurement results of the      |
// |            period meter. PERIOD_METER_AVG_EN adds the averaged outputs.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
interface slow_clock_period_meter_if #(
    parameter int CNT_W = 25
);
    logic             slow_in;
    logic             clear;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high_time;
    logic             period_valid;
    logic             locked;
    logic             stalled;
`ifdef PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] avg_period;
    logic             avg_valid;

    modport master (
        output slow_in, clear,
        input  period, high_time, period_valid, locked, stalled, avg_period, avg_valid
    );
    modport slave (
        input  slow_in, clear,
        output period, high_time, period_valid, locked, stalled, avg_period, avg_valid
    );
`else
    modport master (
        output slow_in, clear,
        input  period, high_time, period_valid, locked, stalled
    );
    modport slave (
        input  slow_in, clear,
        output period, high_time, period_valid, locked, stalled
    );
`endif
endinterface
`default_nettype wire

// File: rtl/slow_clock_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : slow_clock_period_meter                                       |
// | Purpose  : Measures period and high time of an asynchronous slow clock   |
// |            in clk cycles and flags a stalled input. Define               |
// |            PERIOD_METER_AVG_EN to add a 4-period running average.        |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module slow_clock_period_meter #(
    parameter int CNT_W       = 25,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 2**CNT_W - 1
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    slow_clock_period_meter_if.slave  bus
);
    localparam logic [1:0]       C_IDLE       = 2'd0;
    localparam logic [1:0]       C_MEASURE    = 2'd1;
    localparam logic [1:0]       C_STALLED    = 2'd2;
    localparam logic [CNT_W-1:0] C_TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_dly_q, s_dly_d;
    logic                   w_s, w_rise, w_fall;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hcnt_q, hcnt_d;
    logic [CNT_W-1:0]       period_q, period_d;
    logic [CNT_W-1:0]       high_time_q, high_time_d;
    logic                   period_valid_q, period_valid_d;
    logic                   locked_q, locked_d;
    logic                   stalled_q, stalled_d;

    assign sync_d  = {sync_q[SYNC_STAGES-2:0], bus.slow_in};
    assign w_s     = sync_q[SYNC_STAGES-1];
    assign s_dly_d = w_s;
    assign w_rise  = w_s & ~s_dly_q;
    assign w_fall  = ~w_s & s_dly_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hcnt_d         = hcnt_q;
        period_d       = period_q;
        high_time_d    = high_time_q;
        period_valid_d = 1'b0;
        locked_d       = locked_q;
        stalled_d      = stalled_q;

        if (w_rise) begin
            hcnt_d = '0;
        end else if (w_s && (hcnt_q != C_CNT_MAX)) begin
            hcnt_d = hcnt_q + 1'b1;
        end

        case (state_q)
            C_IDLE: begin
                cnt_d = '0;
                if (w_rise) begin
                    state_d = C_MEASURE;
                end
            end
            C_MEASURE: begin
                if (w_fall) begin
                    high_time_d = hcnt_q + 1'b1;
                end
                // A rise arriving on the timeout cycle still counts as a valid period
                if (w_rise) begin
                    period_d       = cnt_q + 1'b1;
                    period_valid_d = 1'b1;
                    locked_d       = 1'b1;
                    cnt_d          = '0;
                end else if (cnt_q >= C_TIMEOUT_M1) begin
                    stalled_d = 1'b1;
                    cnt_d     = C_TIMEOUT_M1;
                    state_d   = C_STALLED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            C_STALLED: begin
                if (w_rise) begin
                    stalled_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = C_MEASURE;
                end else begin
                    cnt_d = C_TIMEOUT_M1;
                end
            end
            default: begin
                state_d = C_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (bus.clear) begin
            state_d        = C_IDLE;
            cnt_d          = '0;
            hcnt_d         = '0;
            period_d       = '0;
            high_time_d    = '0;
            period_valid_d = 1'b0;
            locked_d       = 1'b0;
            stalled_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q         <= '0;
            s_dly_q        <= 1'b0;
            state_q        <= C_IDLE;
            cnt_q          <= '0;
            hcnt_q         <= '0;
            period_q       <= '0;
            high_time_q    <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            stalled_q      <= 1'b0;
        end else begin
            sync_q         <= sync_d;
            s_dly_q        <= s_dly_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hcnt_q         <= hcnt_d;
            period_q       <= period_d;
            high_time_q    <= high_time_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            stalled_q      <= stalled_d;
        end
    end

    assign bus.period       = period_q;
    assign bus.high_time    = high_time_q;
    assign bus.period_valid = period_valid_q;
    assign bus.locked       = locked_q;
    assign bus.stalled      = stalled_q;

`ifdef PERIOD_METER_AVG_EN
    logic [CNT_W-1:0] hist_q [4];
    logic [CNT_W-1:0] hist_d [4];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [2:0]       fill_q, fill_d;
    logic [CNT_W+1:0] sum_q, sum_d;
    logic [CNT_W+1:0] w_oldest, w_sum_next;
    logic [CNT_W-1:0] avg_period_q, avg_period_d;
    logic             avg_valid_q, avg_valid_d;
    logic             w_enter_stall;

    assign w_enter_stall = (state_d == C_STALLED) && (state_q != C_STALLED);
    // Once the ring is full the slot under the write pointer is the oldest period
    assign w_oldest      = (fill_q == 3'd4) ? {2'b00, hist_q[wr_ptr_q]} : '0;
    assign w_sum_next    = sum_q + {2'b00, period_q} - w_oldest;

    always_comb begin
        hist_d       = hist_q;
        wr_ptr_d     = wr_ptr_q;
        fill_d       = fill_q;
        sum_d        = sum_q;
        avg_period_d = avg_period_q;
        avg_valid_d  = 1'b0;

        if (bus.clear) begin
            wr_ptr_d     = '0;
            fill_d       = '0;
            sum_d        = '0;
            avg_period_d = '0;
        end else if (w_enter_stall) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            sum_d    = '0;
        end else if (period_valid_q) begin
            hist_d[wr_ptr_q] = period_q;
            wr_ptr_d         = wr_ptr_q + 1'b1;
            sum_d            = w_sum_next;
            fill_d           = (fill_q == 3'd4) ? 3'd4 : fill_q + 1'b1;
            if (fill_q >= 3'd3) begin
                avg_valid_d  = 1'b1;
                avg_period_d = w_sum_next[CNT_W+1:2];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            fill_q       <= '0;
            sum_q        <= '0;
            avg_period_q <= '0;
            avg_valid_q  <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_q       <= fill_d;
            sum_q        <= sum_d;
            avg_period_q <= avg_period_d;
            avg_valid_q  <= avg_valid_d;
        end
    end

    assign bus.avg_period = avg_period_q;
    assign bus.avg_valid  = avg_valid_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_slow_clock_period_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_slow_clock_period_meter                                    |
// | Purpose  : Self-checking bench; expected reports come from the rise/fall |
// |            timing of the generated slow_in waveform.                     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_slow_clock_period_meter;
    localparam int CNT_W       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 200;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    slow_clock_period_meter_if #(.CNT_W(CNT_W)) bus ();

    slow_clock_period_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit cur_lvl   = 1'b0;
    bit have_ref  = 1'b0;
    int last_rise = 0;
    int last_high = 0;
    int hist[$];
    int exp_p[$], exp_h[$], exp_c[$], exp_a[$], exp_ac[$];

    // Observations
    int obs_p[$], obs_h[$], obs_c[$], obs_a[$], obs_ac[$];
    int last_pv_cyc = 0;
    int stall_gap   = -1;
    bit stalled_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.period_valid === 1'b1) begin
                obs_p.push_back(int'(bus.period));
                obs_h.push_back(int'(bus.high_time));
                obs_c.push_back(cyc);
                last_pv_cyc = cyc;
            end
            if (bus.stalled === 1'b1 && !stalled_prev) begin
                stall_gap = cyc - last_pv_cyc;
            end
            stalled_prev = (bus.stalled === 1'b1);
`ifdef PERIOD_METER_AVG_EN
            if (bus.avg_valid === 1'b1) begin
                obs_a.push_back(int'(bus.avg_period));
                obs_ac.push_back(cyc);
            end
`endif
        end
    end

    // Drive slow_in to v for n cycles; the model turns rise/fall times into reports.
    task automatic drive_level(input bit v, input int n);
        int gap;
        if (v && !cur_lvl) begin
            gap = cyc - last_rise;
            if (have_ref && gap <= TIMEOUT) begin
                exp_p.push_back(gap);
                exp_h.push_back(last_high);
                exp_c.push_back(cyc);
                hist.push_back(gap);
                if (hist.size() > 4) void'(hist.pop_front());
                if (hist.size() == 4) begin
                    exp_a.push_back((hist[0] + hist[1] + hist[2] + hist[3]) / 4);
                    exp_ac.push_back(cyc);
                end
            end else if (have_ref) begin
                hist.delete();
            end
            have_ref  = 1'b1;
            last_rise = cyc;
        end else if (!v && cur_lvl && have_ref) begin
            last_high = cyc - last_rise;
        end
        cur_lvl     = v;
        bus.slow_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wave(input int h, input int l);
        drive_level(1'b1, h);
        drive_level(1'b0, l);
    endtask

    task automatic model_clear();
        have_ref  = 1'b0;
        last_high = 0;
        hist.delete();
    endtask

    task automatic flush(input string name);
        repeat (6) @(posedge clk);
        #1;
        chk({name, "_count"}, obs_p.size(), exp_p.size());
        for (int i = 0; i < obs_p.size() && i < exp_p.size(); i++) begin
            chk({name, "_period"}, obs_p[i], exp_p[i]);
            chk({name, "_high"}, obs_h[i], exp_h[i]);
            chk({name, "_latency"}, obs_c[i] - exp_c[i], SYNC_STAGES + 1);
        end
`ifdef PERIOD_METER_AVG_EN
        chk({name, "_avg_count"}, obs_a.size(), exp_a.size());
        for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++) begin
            chk({name, "_avg"}, obs_a[i], exp_a[i]);
            chk({name, "_avg_latency"}, obs_ac[i] - exp_ac[i], SYNC_STAGES + 2);
        end
`endif
        obs_p.delete(); obs_h.delete(); obs_c.delete(); obs_a.delete(); obs_ac.delete();
        exp_p.delete(); exp_h.delete(); exp_c.delete(); exp_a.delete(); exp_ac.delete();
    endtask

    task automatic pulse_clear();
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        model_clear();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.slow_in = 1'b0;
        bus.clear   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset held while the input toggles
        for (int i = 0; i < 12; i++) begin
            bus.slow_in = ~bus.slow_in;
            @(posedge clk);
            #1;
        end
        chk("rst_period", bus.period, 0);
        chk("rst_high_time", bus.high_time, 0);
        chk("rst_period_valid", bus.period_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_stalled", bus.stalled, 0);
        bus.slow_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;

        // 51 high / 51 low square wave
        wave(51, 51);
        chk("first_rise_no_pv", obs_p.size(), 0);
        repeat (4) wave(51, 51);
        chk("square_locked", bus.locked, 1);
        wave(4, 4);
        flush("square");

        // 30% duty at period 40, then period 64
        repeat (4) wave(12, 28);
        repeat (3) wave(20, 44);
        wave(4, 4);
        flush("duty");

        // Timeout boundary and stall recovery
        repeat (3) wave(30, 70);
        wave(10, 190);
        drive_level(1'b1, 10);
        chk("no_stall_at_timeout", bus.stalled, 0);
        drive_level(1'b0, 196);
        chk("stalled_set", bus.stalled, 1);
        chk("stall_period_held", bus.period, 200);
        chk("stall_locked_held", bus.locked, 1);
        chk("stall_delay", stall_gap, TIMEOUT);
        drive_level(1'b0, 10);
        drive_level(1'b1, 30);
        chk("stall_exit", bus.stalled, 0);
        drive_level(1'b0, 70);
        wave(30, 70);
        wave(4, 4);
        flush("stall");

        // Clear coinciding with a detected rise
        repeat (2) wave(20, 30);
        bus.slow_in = 1'b1;
        cur_lvl     = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        model_clear();
        chk("clear_period", bus.period, 0);
        chk("clear_locked", bus.locked, 0);
        chk("clear_high_time", bus.high_time, 0);
        chk("clear_pv", bus.period_valid, 0);
        repeat (17) @(posedge clk);
        #1;
        drive_level(1'b0, 30);
        repeat (2) wave(20, 30);
        wave(4, 4);
        flush("clear");

`ifdef PERIOD_METER_AVG_EN
        pulse_clear();
        wave(50, 50); wave(50, 50); wave(50, 54); wave(50, 54);
        wave(4, 4);
        flush("avg_a");
        pulse_clear();
        wave(50, 51); wave(50, 52); wave(50, 52); wave(50, 52);
        wave(4, 4);
        flush("avg_b");
`endif

        // Randomized duty cycles and periods
        for (int i = 0; i < 24; i++) begin
            wave(int'($urandom_range(2, 90)), int'($urandom_range(2, 90)));
        end
        wave(4, 4);
        flush("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
